// File: rtl/sseg_pattern_scanner_if.sv
// Pin-side bundle of the seven-segment scanner: display controls in,
// anode/cathode drive and animation frame status out.
interface sseg_pattern_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                            enable;
  logic [1:0]                      mode;
  logic [NUM_DIGITS-1:0]           anode;
  logic [7:0]                      cathodes;
  logic                            frame_tick;
  logic [$clog2(2*NUM_DIGITS)-1:0] frame_idx;

  modport master (
    output enable, mode,
    input  anode, cathodes, frame_tick, frame_idx
  );

  modport slave (
    input  enable, mode,
    output anode, cathodes, frame_tick, frame_idx
  );
endinterface

// File: rtl/sseg_pattern_scanner.sv
// N-digit multiplexed seven-segment driver with clock-enable scan/frame
// dividers and a four-mode animation engine (heartbeat, chase, blink, blank).
module sseg_pattern_scanner #(
  parameter int NUM_DIGITS       = 4,
  parameter int CLK_HZ           = 100_000_000,
  parameter int SCAN_HZ          = 1000,
  parameter int FRAME_HZ         = 72,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sseg_pattern_scanner_if.slave  bus
);
  localparam int SCAN_DIV  = CLK_HZ / (SCAN_HZ * NUM_DIGITS);
  localparam int FRAME_DIV = CLK_HZ / FRAME_HZ;
  localparam int H         = NUM_DIGITS / 2;
  localparam int DW        = $clog2(NUM_DIGITS);
  localparam int FW        = $clog2(2 * NUM_DIGITS);
  localparam int SW        = $clog2(SCAN_DIV);
  localparam int RW        = $clog2(FRAME_DIV);

  localparam logic [7:0] BLANK = 8'hFF;
  localparam logic [7:0] BAR_L = 8'hCF;
  localparam logic [7:0] BAR_R = 8'hF9;
  localparam logic [7:0] DASH  = 8'hBF;
  localparam logic [7:0] ALL   = 8'h00;

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic [1:0] {
    MODE_HEART = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_BLANK = 2'd3
  } mode_t;

  function automatic logic [FW-1:0] frame_last(input mode_t m);
    case (m)
      MODE_HEART: frame_last = FW'(2 * H - 1);
      MODE_CHASE: frame_last = FW'(NUM_DIGITS - 1);
      MODE_BLINK: frame_last = FW'(1);
      default:    frame_last = '0;
    endcase
  endfunction

  function automatic logic [7:0] glyph(input logic [DW-1:0] digit,
                                       input mode_t m,
                                       input logic [FW-1:0] f);
    int i;
    int fi;
    int r;
    glyph = BLANK;
    i  = int'(digit);
    fi = int'(f);
    case (m)
      MODE_HEART: begin
        // Ring radius grows for the first H frames, then shrinks back.
        r = (fi < H) ? fi : 2 * H - 1 - fi;
        if (i < H) begin
          if (H - 1 - i == r) glyph = BAR_R;
        end else if (i - H == r) begin
          glyph = BAR_L;
        end
      end
      MODE_CHASE: if (i == fi % NUM_DIGITS) glyph = DASH;
      MODE_BLINK: if (fi == 0) glyph = ALL;
      default:    glyph = BLANK;
    endcase
  endfunction

  logic [SW-1:0]         scan_cnt, scan_cnt_nxt;
  logic [RW-1:0]         frame_cnt, frame_cnt_nxt;
  logic [DW-1:0]         digit, digit_nxt;
  mode_t                 mode_r, mode_nxt;
  logic [FW-1:0]         fidx, fidx_nxt;
  logic                  live, live_nxt;
  logic                  scan_tick, frame_wrap;
  logic [NUM_DIGITS-1:0] sel;
  logic [NUM_DIGITS-1:0] anode_p1, anode_nxt;
  logic [7:0]            cathodes_p1, cathodes_nxt;
  logic                  frame_tick_p1;

  always_comb begin
    scan_tick     = (scan_cnt == SW'(SCAN_DIV - 1));
    frame_wrap    = (frame_cnt == RW'(FRAME_DIV - 1));
    scan_cnt_nxt  = scan_tick  ? '0 : scan_cnt + SW'(1);
    frame_cnt_nxt = frame_wrap ? '0 : frame_cnt + RW'(1);

    digit_nxt = digit;
    if (scan_tick)
      digit_nxt = (digit == DW'(NUM_DIGITS - 1)) ? '0 : digit + DW'(1);

    // A new mode takes effect only on a frame boundary and restarts its animation.
    mode_nxt = mode_r;
    fidx_nxt = fidx;
    if (frame_wrap) begin
      if (mode_t'(bus.mode) != mode_r) begin
        mode_nxt = mode_t'(bus.mode);
        fidx_nxt = '0;
      end else begin
        fidx_nxt = (fidx == frame_last(mode_r)) ? '0 : fidx + FW'(1);
      end
    end

    // Output is live only once a scan tick has passed with enable high.
    live_nxt = bus.enable & (live | scan_tick);

    sel       = NUM_DIGITS'(1) << digit;
    anode_nxt = ANODE_OFF;
    if (bus.enable && live && !scan_tick)
      anode_nxt = (ANODE_ACTIVE_LOW != 0) ? ~sel : sel;

    cathodes_nxt = live_nxt ? glyph(digit_nxt, mode_nxt, fidx_nxt) : BLANK;
  end

  // Stage boundary: all state and registered pin drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt      <= '0;
      frame_cnt     <= '0;
      digit         <= '0;
      mode_r        <= MODE_HEART;
      fidx          <= '0;
      live          <= 1'b0;
      anode_p1      <= ANODE_OFF;
      cathodes_p1   <= BLANK;
      frame_tick_p1 <= 1'b0;
    end else begin
      scan_cnt      <= scan_cnt_nxt;
      frame_cnt     <= frame_cnt_nxt;
      digit         <= digit_nxt;
      mode_r        <= mode_nxt;
      fidx          <= fidx_nxt;
      live          <= live_nxt;
      anode_p1      <= anode_nxt;
      cathodes_p1   <= cathodes_nxt;
      frame_tick_p1 <= frame_wrap;
    end
  end

  assign bus.anode      = anode_p1;
  assign bus.cathodes   = cathodes_p1;
  assign bus.frame_tick = frame_tick_p1;
  assign bus.frame_idx  = fidx;
endmodule

// File: tb/tb_sseg_pattern_scanner.sv
// Directed bench: 4-digit active-low instance walks scan, heartbeat, mode switch,
// blink/enable and async reset; a 6-digit active-high instance covers generality.
module tb_sseg_pattern_scanner;
  logic clk;
  logic rst_n;
  int   k;
  int   errors;
  int   checks;

  sseg_pattern_scanner_if #(.NUM_DIGITS(4)) bus_a ();
  sseg_pattern_scanner_if #(.NUM_DIGITS(6)) bus_b ();

  sseg_pattern_scanner #(
    .NUM_DIGITS(4), .CLK_HZ(1000), .SCAN_HZ(50), .FRAME_HZ(100), .ANODE_ACTIVE_LOW(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  sseg_pattern_scanner #(
    .NUM_DIGITS(6), .CLK_HZ(1200), .SCAN_HZ(50), .FRAME_HZ(120), .ANODE_ACTIVE_LOW(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, k, obs, exp);
    end
  endtask

  // Advance to the falling edge that follows rising edge number 'target'.
  task automatic adv(input int target);
    while (k < target) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  logic [3:0] scan_exp [1:16];

  initial begin
    scan_exp = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hD, 4'hD, 4'hD,
                 4'hD, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7};
    errors = 0;
    checks = 0;
    k      = 0;
    rst_n  = 1'b0;
    bus_a.enable = 1'b1;
    bus_a.mode   = 2'd3;
    bus_b.enable = 1'b1;
    bus_b.mode   = 2'd0;

    repeat (2) @(negedge clk);
    check("rst_anode_a", bus_a.anode, 4'hF);
    check("rst_cath_a", bus_a.cathodes, 8'hFF);
    check("rst_tick_a", bus_a.frame_tick, 1'b0);
    check("rst_idx_a", bus_a.frame_idx, 3'd0);
    check("rst_anode_b", bus_b.anode, 6'h00);

    rst_n = 1'b1;

    for (int i = 1; i <= 16; i++) begin
      adv(i);
      check("scan_anode", bus_a.anode, scan_exp[i]);
      if (i == 7)  check("boot_heart_cath", bus_a.cathodes, 8'hF9);
      if (i == 9)  check("tick_low_9", bus_a.frame_tick, 1'b0);
      if (i == 10) check("tick_high_10", bus_a.frame_tick, 1'b1);
      if (i == 11) check("tick_low_11", bus_a.frame_tick, 1'b0);
      if (i == 12) check("blank_cath", bus_a.cathodes, 8'hFF);
    end

    adv(22);
    check("b_anode_d5", bus_b.anode, 6'h20);
    check("b_cath_d5", bus_b.cathodes, 8'hCF);
    check("b_idx_f2", bus_b.frame_idx, 4'd2);
    adv(24);
    check("b_anode_gap", bus_b.anode, 6'h00);
    adv(25);
    bus_a.mode = 2'd0;
    adv(26);
    check("b_anode_d0", bus_b.anode, 6'h01);
    check("b_cath_d0", bus_b.cathodes, 8'hF9);
    adv(30);
    check("b_anode_d1", bus_b.anode, 6'h02);
    check("b_cath_d1", bus_b.cathodes, 8'hFF);

    adv(32); check("hb_f0_d2", bus_a.cathodes, 8'hCF); check("hb_f0_an", bus_a.anode, 4'hB);
    adv(37); check("hb_f0_d3", bus_a.cathodes, 8'hFF);
    adv(40); check("hb_idx1", bus_a.frame_idx, 3'd1);
    adv(42); check("hb_f1_d0", bus_a.cathodes, 8'hF9); check("hb_f1_an", bus_a.anode, 4'hE);
    adv(47); check("hb_f1_d1", bus_a.cathodes, 8'hFF);
    adv(50); check("b_idx5", bus_b.frame_idx, 4'd5);
    adv(52); check("hb_f2_d2", bus_a.cathodes, 8'hFF);
    adv(57); check("hb_f2_d3", bus_a.cathodes, 8'hCF);
    adv(59); check("hb_idx2", bus_a.frame_idx, 3'd2);
    adv(60); check("b_idx_wrap", bus_b.frame_idx, 4'd0);
    adv(62); check("hb_f3_d0", bus_a.cathodes, 8'hFF);
    adv(67); check("hb_f3_d1", bus_a.cathodes, 8'hF9);
    adv(69); check("hb_idx3", bus_a.frame_idx, 3'd3); check("hb_tick_69", bus_a.frame_tick, 1'b0);
    adv(70); check("hb_idx_wrap", bus_a.frame_idx, 3'd0); check("hb_tick_70", bus_a.frame_tick, 1'b1);
    adv(71); check("hb_tick_71", bus_a.frame_tick, 1'b0);

    adv(94);
    bus_a.mode = 2'd1;
    adv(96);
    check("sw_hold_cath", bus_a.cathodes, 8'hCF);
    check("sw_hold_idx", bus_a.frame_idx, 3'd2);
    adv(100); check("sw_idx0", bus_a.frame_idx, 3'd0); check("sw_tick", bus_a.frame_tick, 1'b1);
    adv(101); check("ch_f0_an", bus_a.anode, 4'hE); check("ch_f0_d0", bus_a.cathodes, 8'hBF);
    adv(106); check("ch_f0_d1", bus_a.cathodes, 8'hFF);
    adv(112); check("ch_f1_an", bus_a.anode, 4'hB); check("ch_f1_d2", bus_a.cathodes, 8'hFF);
    adv(122); check("ch_f2_d0", bus_a.cathodes, 8'hFF);
    adv(130); check("ch_idx3", bus_a.frame_idx, 3'd3);
    adv(137); check("ch_f3_an", bus_a.anode, 4'h7); check("ch_f3_d3", bus_a.cathodes, 8'hBF);
    adv(140); check("ch_idx_wrap", bus_a.frame_idx, 3'd0);

    adv(141);
    bus_a.mode = 2'd2;
    adv(152); check("bl_f0_an", bus_a.anode, 4'hB); check("bl_f0_cath", bus_a.cathodes, 8'h00);
    adv(162); check("bl_f1_an", bus_a.anode, 4'hE); check("bl_f1_cath", bus_a.cathodes, 8'hFF);
    adv(172); check("bl_f2_cath", bus_a.cathodes, 8'h00);
    adv(173);
    bus_a.enable = 1'b0;
    adv(174); check("en_off_an", bus_a.anode, 4'hF); check("en_off_cath", bus_a.cathodes, 8'hFF);
    adv(176);
    bus_a.enable = 1'b1;
    adv(178); check("en_wait_an178", bus_a.anode, 4'hF);
    adv(179); check("en_wait_an179", bus_a.anode, 4'hF); check("en_wait_cath", bus_a.cathodes, 8'hFF);
    adv(181); check("en_back_an", bus_a.anode, 4'hE); check("en_back_cath", bus_a.cathodes, 8'hFF);
    adv(191); check("bl_f0b_an", bus_a.anode, 4'hB); check("bl_f0b_cath", bus_a.cathodes, 8'h00);
    adv(202); check("pre_rst_idx", bus_a.frame_idx, 3'd1);

    #2 rst_n = 1'b0;
    #1;
    check("arst_anode", bus_a.anode, 4'hF);
    check("arst_cath", bus_a.cathodes, 8'hFF);
    check("arst_idx", bus_a.frame_idx, 3'd0);
    check("arst_anode_b", bus_b.anode, 6'h00);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    adv(4); check("rel_an4", bus_a.anode, 4'hF);
    adv(5); check("rel_an5", bus_a.anode, 4'hF);
    adv(6); check("rel_an6", bus_a.anode, 4'hD); check("rel_cath6", bus_a.cathodes, 8'hF9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sseg_pattern_scanner.md
Name: sseg_pattern_scanner

Overview:
Parameterised N-digit multiplexed seven-segment driver with a built-in animation engine, the next-generation successor to the fixed 4-digit heartbeat display.
- Replaces the derived 72 Hz clock with clock-enable ticks on the single system clock.
- Supports any even digit count, four selectable animation modes, ghost-suppression blanking and a global enable.
- Sits directly between the board clock/reset and the anode/cathode pins.

Parameters:
NUM_DIGITS, 4, number of digits; even, >=2
CLK_HZ, 100_000_000, input clock frequency
SCAN_HZ, 1000, per-digit refresh rate; SCAN_DIV = CLK_HZ/(SCAN_HZ*NUM_DIGITS), integer, >=2
FRAME_HZ, 72, animation frame rate; FRAME_DIV = CLK_HZ/FRAME_HZ, integer, >=2
ANODE_ACTIVE_LOW, 1, 1: anode lit = 0; 0: anode lit = 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1: display driven; 0: all anodes off, cathodes 8'hFF, counters keep running
mode  in  2  0 heartbeat, 1 chase, 2 blink, 3 blank
anode  out  NUM_DIGITS  one-hot digit select, polarity per ANODE_ACTIVE_LOW; bit 0 = rightmost
cathodes  out  8  {dp,g,f,e,d,c,b,a}, active-low
frame_tick  out  1  one-cycle pulse per animation frame
frame_idx  out  $clog2(2*NUM_DIGITS)  current frame index

Behaviour:
- Reset (async assert, sync release): anode all-off, cathodes 8'hFF, frame_tick 0, frame_idx 0, digit index 0, both dividers 0, registered mode 0.
- Glyphs: BLANK 8'hFF; BAR_L (e,f) 8'hCF; BAR_R (b,c) 8'hF9; DASH (g) 8'hBF; ALL (8.) 8'h00.
- Scan divider: counts 0..SCAN_DIV-1, wraps. The cycle it equals SCAN_DIV-1 is the scan tick.
  - Edge after tick: digit index increments (wraps NUM_DIGITS-1 -> 0), anode -> all-off, cathodes -> glyph for the new digit.
  - Next edge: anode -> one-hot of the new digit.
  - Result: exactly one all-off blanking cycle per digit change; otherwise exactly one anode is active.
- Frame divider: counts 0..FRAME_DIV-1. On the edge after it equals FRAME_DIV-1:
  - frame_tick = 1 for one cycle.
  - frame_idx advances, wrapping at L-1, where L = 2H (heartbeat, H = NUM_DIGITS/2), NUM_DIGITS (chase), 2 (blink), 1 (blank).
- Mode change: mode is sampled only at frame ticks.
  - If the new mode differs from the registered mode, the registered mode updates and frame_idx -> 0 on that tick (no advance).
  - Same mode: normal advance.
- Heartbeat: r = (f < H) ? f : 2H-1-f.
  - Right-half digit i (i < H): distance d = H-1-i; shows BAR_R when d == r, else BLANK.
  - Left-half digit i: distance d = i-H; shows BAR_L when d == r, else BLANK.
  - Pulse expands outward, then contracts.
- Chase: digit (f mod NUM_DIGITS) shows DASH, others BLANK.
- Blink: all digits show ALL when f == 0, BLANK when f == 1.
- Blank: all BLANK, scanning continues.
- Cathodes always reflect the registered mode and frame_idx; a mid-frame mode input change has no visible effect until the next tick.
- enable = 0: anode all-off and cathodes 8'hFF from the next edge. enable rising: normal output resumes at the next scan tick (anode stays off until then).
- Reset mid-operation: all outputs go to reset values immediately, without waiting for a clock edge.

Test Plan:
- Scan basic: CLK_HZ=1000, SCAN_HZ=50, NUM_DIGITS=4 (SCAN_DIV=5), mode=3, enable=1 -> anode sequence after reset: all-off, then 4'b1101 (digit 1) held 4 cycles, 1 cycle 4'b1111, 4'b1011 for 4 cycles, ...; never two bits low at once.
- Heartbeat: FRAME_HZ=100 (FRAME_DIV=10), mode=0.
  - Per frame, digits {3,2,1,0} show: f0 {BLANK,CF,F9,BLANK}; f1 {CF,BLANK,BLANK,F9}; f2 same as f1; f3 same as f0.
  - frame_idx wraps 3 -> 0; frame_tick is a single cycle every 10 clocks.
- Mode switch mid-frame: mode 0 -> 1 at frame_idx=2, halfway through the frame -> display unchanged until the tick; at the tick frame_idx=0, digit 0 shows 8'hBF; frame_idx then cycles 0..3 with DASH moving one digit per frame.
- Blink and enable: mode=2 -> cathodes alternate 8'h00 and 8'hFF per frame.
  - enable=0 -> anode 4'b1111 and cathodes 8'hFF on the next edge.
  - enable=1 -> anode reasserts only after the next scan tick.
- Async reset: assert rst_n=0 between clock edges mid-scan -> anode 4'b1111, cathodes 8'hFF, frame_idx 0 before the next edge; after release, the first scan tick lands on cycle 5.
- Generality: NUM_DIGITS=6, ANODE_ACTIVE_LOW=0, heartbeat -> L=6, anode active-high one-hot; f2 lights digits 0 (F9) and 5 (CF).
